// File: rtl/mem_arbiter.sv
// mem_arbiter: lets CORE_COUNT cores share one single-port RAM that has a registered
// address and a one-cycle read latency.
//
// Each cycle the arbiter grants one requesting core, using round-robin priority by
// default. It drives that core's access onto the RAM port and routes the read data
// back to the issuing core one cycle later.
//
// Optional feature macro: MEM_ARB_FIXED_PRIORITY_EN
//   undefined (default) : round-robin priority. The search starts at a pointer that
//                         moves to one past the last grantee.
//   defined             : fixed priority. Core 0 is highest and CORE_COUNT-1 lowest.
//                         The pointer is removed.
//
// Ports:
//   clk        in   system clock, rising edge
//   rstN       in   asynchronous active-low reset
//   req        in   [CORE_COUNT]            per-core request, held until granted
//   wrEnIn     in   [CORE_COUNT]            per-core op: 1 = write, 0 = read
//   addrIn     in   [CORE_COUNT*ADDR_WIDTH] flattened addresses, core i at i*ADDR_WIDTH
//   dataInIn   in   [CORE_COUNT*DATA_WIDTH] flattened write data, same packing
//   grant      out  [CORE_COUNT]            one-hot, the core issued to the RAM this cycle
//   rdValid    out  [CORE_COUNT]            one-hot, owner of rdData this cycle
//   rdData     out  [DATA_WIDTH]            read data, shared by all cores
//   ramWrEn    out                          RAM write enable
//   ramAddr    out  [ADDR_WIDTH]            RAM address
//   ramDataIn  out  [DATA_WIDTH]            RAM write data
//   ramDataOut in   [DATA_WIDTH]            RAM read data
module mem_arbiter #(
    parameter int CORE_COUNT = 4,
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rstN,
    input  logic [CORE_COUNT-1:0]            req,
    input  logic [CORE_COUNT-1:0]            wrEnIn,
    input  logic [CORE_COUNT*ADDR_WIDTH-1:0] addrIn,
    input  logic [CORE_COUNT*DATA_WIDTH-1:0] dataInIn,
    output logic [CORE_COUNT-1:0]            grant,
    output logic [CORE_COUNT-1:0]            rdValid,
    output logic [DATA_WIDTH-1:0]            rdData,
    output logic                             ramWrEn,
    output logic [ADDR_WIDTH-1:0]            ramAddr,
    output logic [DATA_WIDTH-1:0]            ramDataIn,
    input  logic [DATA_WIDTH-1:0]            ramDataOut
);

    localparam int PTR_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_any;
    logic                  grant_act;
    logic [CORE_COUNT-1:0] grant_onehot;
    logic [CORE_COUNT-1:0] rd_owner_q;
    logic [CORE_COUNT-1:0] rd_owner_d;

`ifndef MEM_ARB_FIXED_PRIORITY_EN
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W:0]   search_sum;
`endif
    logic [PTR_W-1:0] search_idx;

    // Take the first requester found, starting the search at the priority origin.
    always_comb begin
        grant_idx  = '0;
        grant_any  = 1'b0;
        search_idx = '0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
        search_sum = '0;
`endif
        for (int i = 0; i < CORE_COUNT; i++) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
            search_idx = PTR_W'(i);
`else
            // Wrap the search at CORE_COUNT, which need not be a power of two.
            search_sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (search_sum >= (PTR_W+1)'(CORE_COUNT)) begin
                search_sum = search_sum - (PTR_W+1)'(CORE_COUNT);
            end
            search_idx = search_sum[PTR_W-1:0];
`endif
            if (!grant_any && req[search_idx]) begin
                grant_any = 1'b1;
                grant_idx = search_idx;
            end
        end
    end

    // Outputs are masked during reset so that no RAM write slips through.
    assign grant_act = grant_any & rstN;

    always_comb begin
        grant_onehot = '0;
        if (grant_act) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ramWrEn   = 1'b0;
        ramAddr   = '0;
        ramDataIn = '0;
        if (grant_act) begin
            ramWrEn   = wrEnIn[grant_idx];
            ramAddr   = addrIn[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            ramDataIn = dataInIn[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // The flops are held in reset whenever rstN is low, so the unmasked grant is safe here.
    always_comb begin
        rd_owner_d = '0;
        if (grant_any && !wrEnIn[grant_idx]) begin
            rd_owner_d[grant_idx] = 1'b1;
        end
    end

`ifndef MEM_ARB_FIXED_PRIORITY_EN
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            if (grant_idx == PTR_W'(CORE_COUNT - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rd_owner_q <= '0;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    assign grant   = grant_onehot;
    assign rdValid = rd_owner_q;
    assign rdData  = ramDataOut;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that lets CORE_COUNT processor cores share one single-port RAM (one read/write per cycle, registered address, one-cycle read latency). Sits directly upstream of the RAM. It muxes the granted core's address, write-enable and write data onto the RAM port, and returns the read data, qualified by a per-core valid pulse, to the core that issued the read.

## Interface
- CORE_COUNT, 4: number of requesting cores (≥2).
- DATA_WIDTH, 12: RAM word width.
- ADDR_WIDTH, 8: RAM address width.
- clk  in  1  system clock; all state updates on rising edge.
- rstN  in  1  reset, asynchronous, active-low.
- req  in  CORE_COUNT  per-core request; held high until granted.
- wrEnIn  in  CORE_COUNT  per-core op: 1 = write, 0 = read; stable while req high.
- addrIn  in  CORE_COUNT*ADDR_WIDTH  flattened addresses; core i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- dataInIn  in  CORE_COUNT*DATA_WIDTH  flattened write data; same packing.
- grant  out  CORE_COUNT  one-hot; high in the cycle core i's access is issued to the RAM.
- rdValid  out  CORE_COUNT  one-hot pulse; rdData belongs to core i this cycle.
- rdData  out  DATA_WIDTH  read data, shared by all cores.
- ramWrEn  out  1  to RAM wrEn.
- ramAddr  out  ADDR_WIDTH  to RAM address.
- ramDataIn  out  DATA_WIDTH  to RAM dataIn.
- ramDataOut  in  DATA_WIDTH  from RAM dataOut.

## Operation
- State: round-robin pointer `ptr` (log2 CORE_COUNT bits), read-return register `rdOwner` (one-hot CORE_COUNT), which holds the grantee of the previous cycle's read.
- Arbitration is combinational within the cycle. grant = the first requesting core found searching from ptr upward, wrapping CORE_COUNT-1 → 0. No request → grant all-zero.
- On any grant to core g: ptr ← (g+1) mod CORE_COUNT at the edge. With no grant, ptr holds.
- RAM drive when granted: ramAddr = addrIn[g], ramDataIn = dataInIn[g], ramWrEn = wrEnIn[g].
- RAM drive when not granted: ramWrEn = 0, ramAddr = 0, ramDataIn = 0.
- A read grant sets rdOwner ← one-hot(g) at the edge. Otherwise rdOwner ← 0. A write grant never produces rdValid.
- rdValid = rdOwner. rdData = ramDataOut, passed through unregistered.
- A core deasserts req, or presents its next request, in the cycle after grant. Keeping req high after grant is a new request.
- Read-after-write to the same address in the following cycle returns the newly written word, because the RAM updates the array at the write edge.
- Single cycle per access. No backpressure on rdValid: cores must accept the return.

## Timing
- Grant latency: 0 cycles. Grant is asserted in the same cycle as req when the core wins.
- Read latency: rdValid and rdData are asserted exactly 1 cycle after grant.
- Throughput: one access per cycle in aggregate. With N cores continuously requesting, each is granted once every N cycles.
- Reset (rstN low, asynchronous): ptr = 0 and rdOwner = 0. grant, rdValid, ramWrEn, ramAddr and ramDataIn are forced to 0 regardless of req. No RAM write can occur while reset is asserted.
- Reset asserted mid-read: the pending rdValid is dropped. The core re-issues the read after reset.
- The first edge after rstN deasserts may grant. Priority then starts at core 0.

## Configuration
- MEM_ARB_FIXED_PRIORITY_EN defined: ptr is removed. Core 0 always has highest priority, descending to core CORE_COUNT-1. Starvation is possible and allowed.
- MEM_ARB_FIXED_PRIORITY_EN undefined (default): the round-robin behaviour above.
- All other behaviour, latency and reset values are identical in both modes.

## Test plan
- Reset: rstN=0 with all req=1 → grant=0, ramWrEn=0, rdValid=0. Release rstN → core 0 granted first.
- Single write then read: core 2 writes addr 0x15 data 0xABC, next cycle reads 0x15 → rdValid=4'b0100 one cycle after the read grant, rdData=0xABC.
- Fairness: all 4 cores hold req for 8 cycles (round-robin build) → grant sequence 0,1,2,3,0,1,2,3.
- Fixed-priority build, same stimulus → grant=0001 for all 8 cycles.
- Mixed read/write: core 1 reads 0x02 (holds 0x111) while core 3 writes 0x02 with 0x777. Core 1 is granted first → core 1 gets 0x111. The following read of 0x02 by any core returns 0x777.
- Reset mid-read: assert rstN low in the cycle after a read grant → rdValid stays 0. No stale rdValid appears after release.
